// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity encodings,
// transmit FSM state type and the parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    // Parity over the low nbits of bits; odd parity is the inverted XOR.
    function automatic logic parity_bit(input logic [7:0] bits, input int nbits, input int mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) begin
                x = x ^ bits[i];
            end else begin
                x = x;
            end
        end
        if (mode == PAR_ODD) begin
            parity_bit = ~x;
        end else begin
            parity_bit = x;
        end
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered full/empty/level flags. The head entry is
// presented combinationally on rdata so the consumer can pop and load in one
// cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic                       empty_next,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    // A write is taken only when there is room; a pop only when data exists.
    always_comb begin
        push_s       = wr & ~full_r;
        pop_s        = rd & ~empty_r;
        level_next_s = level_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + LW'(1);
        end else if (!push_s && pop_s) begin
            level_next_s = level_r - LW'(1);
        end else begin
            level_next_s = level_r;
        end
        empty_next = (level_next_s == LW'(0));
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy and status flags, all registered from the next occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            level_r <= level_next_s;
            full_r  <= (level_next_s == LW'(DEPTH));
            empty_r <= empty_next;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a write FIFO feeding a frame serializer paced by
// a fractional baud accumulator. Frames run back-to-back while data is queued.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int BAUD      = 115200,
    parameter int IN_CLOCK  = 50000000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr,
    input  logic [DATA_BITS-1:0]       data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       idle,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic                       uart_tx
);

    // Baud accumulator
    logic [31:0]          acc_r;
    logic [32:0]          sum_s;
    logic [32:0]          acc_next_s;
    logic                 tick_s;

    // FIFO interface
    logic [DATA_BITS-1:0] head_s;
    logic [7:0]           head8_s;
    logic                 fifo_empty_s;
    logic                 fifo_empty_next_s;
    logic                 pop_s;

    // Serializer
    tx_state_t            state_r;
    tx_state_t            state_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic [2:0]           bit_cnt_r;
    logic [2:0]           bit_cnt_next_s;
    logic                 stop_cnt_r;
    logic                 stop_cnt_next_s;
    logic                 par_r;
    logic                 par_next_s;
    logic                 tx_r;
    logic                 tx_next_s;
    logic                 load_s;

    // Status
    logic                 idle_r;
    logic                 ovf_r;
    logic                 ovf_set_s;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr         (wr),
        .wdata      (data),
        .rd         (pop_s),
        .rdata      (head_s),
        .full       (full),
        .empty      (fifo_empty_s),
        .empty_next (fifo_empty_next_s),
        .level      (level)
    );

    // Fractional baud step: tick whenever the accumulator would reach IN_CLOCK.
    always_comb begin
        sum_s  = {1'b0, acc_r} + 33'(BAUD);
        tick_s = (sum_s >= 33'(IN_CLOCK));
        if (tick_s) begin
            acc_next_s = sum_s - 33'(IN_CLOCK);
        end else begin
            acc_next_s = sum_s;
        end
    end

    // Head entry zero-extended to the width of the parity helper.
    always_comb begin
        head8_s                = 8'd0;
        head8_s[DATA_BITS-1:0] = head_s;
    end

    // Serializer next-state logic; the line only moves on a tick.
    always_comb begin
        state_next_s    = state_r;
        shift_next_s    = shift_r;
        bit_cnt_next_s  = bit_cnt_r;
        stop_cnt_next_s = stop_cnt_r;
        par_next_s      = par_r;
        tx_next_s       = tx_r;
        load_s          = 1'b0;
        pop_s           = 1'b0;
        if (tick_s) begin
            case (state_r)
                IDLE: begin
                    tx_next_s = 1'b1;
                    load_s    = ~fifo_empty_s;
                end
                START: begin
                    tx_next_s      = shift_r[0];
                    shift_next_s   = shift_r >> 1;
                    bit_cnt_next_s = 3'd0;
                    state_next_s   = DATA;
                end
                DATA: begin
                    if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            tx_next_s    = par_r;
                            state_next_s = PAR;
                        end else begin
                            tx_next_s       = 1'b1;
                            stop_cnt_next_s = 1'b0;
                            state_next_s    = STOP;
                        end
                    end else begin
                        tx_next_s      = shift_r[0];
                        shift_next_s   = shift_r >> 1;
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end
                PAR: begin
                    tx_next_s       = 1'b1;
                    stop_cnt_next_s = 1'b0;
                    state_next_s    = STOP;
                end
                STOP: begin
                    if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
                        // Last stop bit ends: chain straight into the next frame if queued.
                        tx_next_s    = 1'b1;
                        state_next_s = IDLE;
                        load_s       = ~fifo_empty_s;
                    end else begin
                        stop_cnt_next_s = stop_cnt_r + 1'b1;
                    end
                end
                default: begin
                    tx_next_s    = 1'b1;
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
        if (load_s) begin
            pop_s        = 1'b1;
            shift_next_s = head_s;
            par_next_s   = parity_bit(head8_s, DATA_BITS, PARITY);
            tx_next_s    = 1'b0;
            state_next_s = START;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Baud accumulator register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= 32'd0;
        end else begin
            acc_r <= acc_next_s[31:0];
        end
    end

    // Serializer state, shifter and line register; reset forces the line idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            shift_r    <= shift_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            stop_cnt_r <= stop_cnt_next_s;
            par_r      <= par_next_s;
            tx_r       <= tx_next_s;
        end
    end

    assign ovf_set_s = wr & full;

    // Idle flag and sticky overflow; a dropped write beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_r <= 1'b1;
            ovf_r  <= 1'b0;
        end else begin
            idle_r <= (state_next_s == IDLE) && fifo_empty_next_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign uart_tx  = tx_r;
    assign idle     = idle_r;
    assign overflow = ovf_r;

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter BAUD, default 115200: serial bit rate in bits/s.
REQ-002 SHALL have parameter IN_CLOCK, default 50000000: clk frequency in Hz; BAUD < IN_CLOCK.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-006 SHALL have parameter DEPTH, default 16: FIFO entries, power of two, minimum 2.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port wr, input, 1 bit: write strobe, one byte per high cycle.
REQ-010 SHALL have port data, input, DATA_BITS bits: byte to enqueue.
REQ-011 SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-012 SHALL have port level, output, $clog2(DEPTH+1) bits: current FIFO occupancy.
REQ-013 SHALL have port idle, output, 1 bit: FIFO empty and no frame in flight.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-015 SHALL have port ovf_clr, input, 1 bit: clears overflow.
REQ-016 SHALL have port uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-017 The baud generator SHALL be a 32-bit fractional accumulator.
- Each clk: if acc + BAUD >= IN_CLOCK, tick = 1 and acc <= acc + BAUD - IN_CLOCK; otherwise acc <= acc + BAUD.
REQ-018 All uart_tx changes SHALL occur only on the clk edge ending a tick cycle; each serial bit lasts exactly one tick interval.
REQ-019 Frame order SHALL be: start (0), DATA_BITS LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-020 Parity SHALL be computed as follows:
- Odd: XOR of the data bits, inverted.
- Even: XOR of the data bits.
REQ-021 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
- IDLE with tick and FIFO non-empty: pop head into shifter, drive 0, go to START.
- START on tick: go to DATA driving bit 0.
- DATA on tick: after bit DATA_BITS-1, go to PAR if PARITY != 0, otherwise STOP.
- PAR on tick: go to STOP.
- STOP ends after STOP_BITS ticks, then returns to IDLE.
REQ-022 Back-to-back frames SHALL occur with no extra idle bit: the tick ending the last stop bit in STOP with FIFO non-empty pops and drives the next start bit directly.
REQ-023 A write SHALL be accepted when wr = 1 and full = 0; the byte is visible for pop from the next cycle.
REQ-024 A write when full = 1 SHALL be dropped and overflow SHALL be set, even if a pop occurs in the same cycle.
REQ-025 A simultaneous accepted write and pop SHALL leave level unchanged.
REQ-026 When set and clear coincide on overflow, set SHALL win over ovf_clr.
REQ-027 Pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-028 full, level and idle SHALL be registered outputs, valid the cycle after the causing event.

Reset
REQ-029 Asserting reset_n low SHALL immediately set the following, aborting any frame mid-bit:
- uart_tx = 1, state = IDLE.
- acc = 0, FIFO pointers = 0, level = 0.
- full = 0, idle = 1, overflow = 0.
REQ-030 After deassertion, the first tick SHALL occur ceil(IN_CLOCK/BAUD) clocks later, at the earliest.

Structure
REQ-031 A shared package uart_pkg SHALL hold the PARITY encodings (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state enum.
REQ-032 The FIFO SHALL be a separate sub-module uart_fifo, parametrised by WIDTH and DEPTH, with the same clk/reset_n.

Verification
REQ-033 Test parameters: IN_CLOCK=16, BAUD=1, DATA_BITS=8, PARITY=0, STOP_BITS=1.
- Write 0x55 -> line reads 0,1,0,1,0,1,0,1,0,1; each bit lasts 16 clk; idle = 1 afterwards.
REQ-034 PARITY=2, DATA_BITS=7, STOP_BITS=2.
- Write 0x07 -> frame 0,1,1,1,0,0,0,0, parity 1, then 1,1.
REQ-035 DEPTH=4.
- Write 0x01..0x04 in consecutive cycles -> level 4, full = 1; four frames sent back-to-back with no idle gap.
REQ-036 Fill to full, then write 0xAA -> 0xAA is never transmitted and overflow = 1.
- Pulse ovf_clr -> overflow = 0.
REQ-037 Assert reset_n low in the middle of data bit 3 -> uart_tx = 1 within the same cycle, level = 0, no further frame.
REQ-038 Test parameters: BAUD=3, IN_CLOCK=10.
- Send 0xFF -> bit durations follow the pattern 4,3,3 clk (tick every 3 or 4 clk); 30 ticks occur in 100 clk.
